// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: FSM states, control-bit
// positions within the EX/MEM control bundles, and MEM/WB error codes.
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Bit positions inside MEM_M
    localparam int MEM_WRITE_BIT = 1;
    localparam int MEM_READ_BIT  = 0;

    // Bit positions inside WB_M / WB_W
    localparam int WB_REGWRITE_BIT = 1;
    localparam int WB_MEMTOREG_BIT = 0;

    // MemErr_W encodings
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ALIGN   = 2'b10;

    // Any read or write request counts as a memory access (2'b11 behaves as a write)
    function automatic logic is_access(input logic [1:0] mem_m);
        return mem_m[MEM_WRITE_BIT] | mem_m[MEM_READ_BIT];
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. Each cycle it either loads an instruction,
// loads a bubble (all zero), or holds. An error load clears RegWrite and
// records the error code so the faulting instruction never writes back.
module mem_wb_reg
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        bubble,
    input  logic        err,
    input  logic [1:0]  err_code,
    input  logic [1:0]  wb_in,
    input  logic [31:0] rdata_in,
    input  logic [31:0] alu_in,
    input  logic [4:0]  wreg_in,
    output logic [1:0]  wb_w,
    output logic [31:0] rdata_w,
    output logic [31:0] alu_w,
    output logic [4:0]  wreg_w,
    output logic [1:0]  err_w
);

    logic [1:0]  wb_q,    wb_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] alu_q,   alu_d;
    logic [4:0]  wreg_q,  wreg_d;
    logic [1:0]  err_q,   err_d;

    // Select next register contents: bubble wins over load, otherwise hold
    always_comb begin
        wb_d    = wb_q;
        rdata_d = rdata_q;
        alu_d   = alu_q;
        wreg_d  = wreg_q;
        err_d   = err_q;
        if (bubble) begin
            wb_d    = '0;
            rdata_d = '0;
            alu_d   = '0;
            wreg_d  = '0;
            err_d   = ERR_NONE;
        end else if (load) begin
            wb_d    = wb_in;
            rdata_d = rdata_in;
            alu_d   = alu_in;
            wreg_d  = wreg_in;
            err_d   = ERR_NONE;
            if (err) begin
                wb_d[WB_REGWRITE_BIT] = 1'b0;
                err_d                 = err_code;
            end
        end
    end

    // Register update with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_q    <= '0;
            rdata_q <= '0;
            alu_q   <= '0;
            wreg_q  <= '0;
            err_q   <= ERR_NONE;
        end else begin
            wb_q    <= wb_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            wreg_q  <= wreg_d;
            err_q   <= err_d;
        end
    end

    assign wb_w    = wb_q;
    assign rdata_w = rdata_q;
    assign alu_w   = alu_q;
    assign wreg_w  = wreg_q;
    assign err_w   = err_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues data-memory requests over a
// variable-latency req/ack port, stalls upstream until ack or timeout,
// and drives the MEM/WB register.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned word accesses are
// rejected without a request and reported as ERR_ALIGN.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  MEM_M,
    input  logic [1:0]  WB_M,
    input  logic [31:0] ALUOut_M,
    input  logic [31:0] WriteData_M,
    input  logic [4:0]  WriteReg_M,
    output logic        StallM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [1:0]  WB_W,
    output logic [31:0] ReadData_W,
    output logic [31:0] ALUOut_W,
    output logic [4:0]  WriteReg_W,
    output logic [1:0]  MemErr_W
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q,   cnt_d;
    logic        req_q,   req_d;
    logic        we_q,    we_d;

    logic        access;
    logic        misaligned;
    logic        stall;
    logic        wb_load;
    logic        wb_bubble;
    logic        wb_err;
    logic [1:0]  err_code;
    logic [31:0] rdata_sel;

    assign access = is_access(MEM_M);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (ALUOut_M[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // FSM next-state, counter, request register and MEM/WB load decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        stall     = 1'b0;
        wb_load   = 1'b0;
        wb_bubble = 1'b0;
        wb_err    = 1'b0;
        err_code  = ERR_NONE;
        rdata_sel = '0;
        case (state_q)
            IDLE: begin
                if (access && !misaligned) begin
                    stall     = 1'b1;
                    wb_bubble = 1'b1;
                    state_d   = WAIT;
                    req_d     = 1'b1;
                    we_d      = MEM_M[MEM_WRITE_BIT];
                    cnt_d     = '0;
                end else if (access) begin
                    wb_load  = 1'b1;
                    wb_err   = 1'b1;
                    err_code = ERR_ALIGN;
                end else begin
                    wb_load = 1'b1;
                end
            end
            WAIT: begin
                // Ack has priority over a simultaneous timeout
                if (dmem_ack) begin
                    wb_load   = 1'b1;
                    rdata_sel = we_q ? 32'h0 : dmem_rdata;
                    req_d     = 1'b0;
                    state_d   = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    wb_load  = 1'b1;
                    wb_err   = 1'b1;
                    err_code = ERR_TIMEOUT;
                    req_d    = 1'b0;
                    state_d  = IDLE;
                end else begin
                    stall     = 1'b1;
                    wb_bubble = 1'b1;
                    cnt_d     = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State, counter and request registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
        end
    end

    assign StallM     = stall;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    // EX/MEM is held during WAIT, so these pass-throughs stay stable
    assign dmem_addr  = ALUOut_M;
    assign dmem_wdata = WriteData_M;

    mem_wb_reg u_mem_wb_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (wb_load),
        .bubble   (wb_bubble),
        .err      (wb_err),
        .err_code (err_code),
        .wb_in    (WB_M),
        .rdata_in (rdata_sel),
        .alu_in   (ALUOut_M),
        .wreg_in  (WriteReg_M),
        .wb_w     (WB_W),
        .rdata_w  (ReadData_W),
        .alu_w    (ALUOut_W),
        .wreg_w   (WriteReg_W),
        .err_w    (MemErr_W)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver pushes the expected MEM/WB
// contents per instruction; a monitor pops and compares on every commit
// edge and checks bubbles on every stalled edge.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  MEM_M;
    logic [1:0]  WB_M;
    logic [31:0] ALUOut_M;
    logic [31:0] WriteData_M;
    logic [4:0]  WriteReg_M;
    logic        StallM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic [1:0]  WB_W;
    logic [31:0] ReadData_W;
    logic [31:0] ALUOut_W;
    logic [4:0]  WriteReg_W;
    logic [1:0]  MemErr_W;

    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic [1:0]  err;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic commit_s    = 1'b0;
    logic stall_s     = 1'b0;

    mem_stage #(.TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MEM_M       (MEM_M),
        .WB_M        (WB_M),
        .ALUOut_M    (ALUOut_M),
        .WriteData_M (WriteData_M),
        .WriteReg_M  (WriteReg_M),
        .StallM      (StallM),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ack    (dmem_ack),
        .WB_W        (WB_W),
        .ReadData_W  (ReadData_W),
        .ALUOut_W    (ALUOut_W),
        .WriteReg_W  (WriteReg_W),
        .MemErr_W    (MemErr_W)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Stall sampler, well after the negedge when ack has been applied
    always @(negedge clk) begin
        #3;
        stall_s = StallM;
    end

    // Monitor: pop on commit edges, require bubbles on stalled edges
    always @(posedge clk) begin
        logic cm;
        logic st;
        exp_t e;
        cm = commit_s;
        st = stall_s;
        #1;
        if (cm) begin
            if (sb_q.size() == 0) begin
                check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("WB_W",       32'(WB_W),       32'(e.wb));
                check("ReadData_W", ReadData_W,      e.rd);
                check("ALUOut_W",   ALUOut_W,        e.alu);
                check("WriteReg_W", 32'(WriteReg_W), 32'(e.wr));
                check("MemErr_W",   32'(MemErr_W),   32'(e.err));
            end
        end else if (st) begin
            check("bubble", {WB_W, ReadData_W[3:0], ALUOut_W[3:0], WriteReg_W, MemErr_W} == '0 &&
                  ReadData_W == 32'h0 && ALUOut_W == 32'h0 ? 32'd0 : 32'd1, 32'd0);
        end
    end

    // Present one instruction and hold it until the stage stops stalling
    task automatic issue(input string name, input logic [1:0] mem, input logic [1:0] wb,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                         input int ack_at, input logic [31:0] rd,
                         input int exp_stall, input int exp_req, input logic exp_we,
                         input logic [1:0] e_wb, input logic [31:0] e_rd, input logic [1:0] e_err);
        int cyc  = 0;
        int reqs = 0;
        bit done = 0;
        MEM_M = mem; WB_M = wb; ALUOut_M = alu; WriteData_M = wd; WriteReg_M = wr;
        dmem_rdata = 32'hBAD0_BAD0;
        sb_q.push_back('{e_wb, e_rd, alu, wr, e_err});
        while (!done) begin
            @(negedge clk);
            dmem_ack   = (ack_at > 0 && cyc == ack_at);
            dmem_rdata = dmem_ack ? rd : 32'hBAD0_BAD0;
            #1;
            if (dmem_req) begin
                reqs++;
                check({name, "_we"},    32'(dmem_we), 32'(exp_we));
                check({name, "_addr"},  dmem_addr,    alu);
                check({name, "_wdata"}, dmem_wdata,   wd);
            end
            if (!StallM) begin
                commit_s = 1'b1;
                done     = 1;
            end else begin
                cyc++;
                if (cyc > 50) begin
                    check({name, "_stall_bound"}, 32'd1, 32'd0);
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #2;
        dmem_ack = 1'b0; commit_s = 1'b0;
        MEM_M = 2'b00; WB_M = 2'b00; ALUOut_M = '0; WriteData_M = '0; WriteReg_M = '0;
        check({name, "_stall_cycles"}, 32'(cyc),  32'(exp_stall));
        check({name, "_req_cycles"},   32'(reqs), 32'(exp_req));
        check({name, "_req_after"},    32'(dmem_req), 32'd0);
        $display("txn %s: stall_cycles=%0d req_cycles=%0d", name, cyc, reqs);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; MEM_M = '0; WB_M = '0; ALUOut_M = '0; WriteData_M = '0;
        WriteReg_M = '0; dmem_rdata = '0; dmem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_StallM",     32'(StallM),     32'd0);
        check("rst_dmem_req",   32'(dmem_req),   32'd0);
        check("rst_dmem_we",    32'(dmem_we),    32'd0);
        check("rst_WB_W",       32'(WB_W),       32'd0);
        check("rst_ReadData_W", ReadData_W,      32'd0);
        check("rst_ALUOut_W",   ALUOut_W,        32'd0);
        check("rst_WriteReg_W", 32'(WriteReg_W), 32'd0);
        check("rst_MemErr_W",   32'(MemErr_W),   32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #2;

        // name      MEM    WB     addr          wdata         wr  ack rdata         stl req we    eWB    eRD           eERR
        issue("alu",     2'b00, 2'b10, 32'h0000_1234, 32'h0,        5'd5, 0, 32'h0,         0, 0, 1'b0, 2'b10, 32'h0,         2'b00);
        issue("load3",   2'b01, 2'b11, 32'h0000_0100, 32'h0,        5'd7, 3, 32'hDEAD_BEEF, 3, 3, 1'b0, 2'b11, 32'hDEAD_BEEF, 2'b00);
        issue("store1",  2'b10, 2'b00, 32'h0000_0200, 32'hA5A5_A5A5, 5'd2, 1, 32'h1234_5678, 1, 1, 1'b1, 2'b00, 32'h0,         2'b00);
        issue("timeout", 2'b01, 2'b11, 32'h0000_0300, 32'h0,        5'd9, 0, 32'h0,         4, 4, 1'b0, 2'b01, 32'h0,         2'b01);
        issue("alu2",    2'b00, 2'b10, 32'h0000_0055, 32'h0,        5'd3, 0, 32'h0,         0, 0, 1'b0, 2'b10, 32'h0,         2'b00);
        issue("ack_last",2'b01, 2'b11, 32'h0000_0304, 32'h0,        5'd6, 4, 32'h0BAD_CAFE, 4, 4, 1'b0, 2'b11, 32'h0BAD_CAFE, 2'b00);
        issue("wr11",    2'b11, 2'b10, 32'h0000_0308, 32'h7777_0001, 5'd8, 2, 32'h5555_5555, 2, 2, 1'b1, 2'b10, 32'h0,         2'b00);
`ifdef MEM_ALIGN_CHECK_EN
        issue("misalign",2'b01, 2'b11, 32'h0000_0102, 32'h0,        5'd4, 0, 32'h0,         0, 0, 1'b0, 2'b01, 32'h0,         2'b10);
`else
        issue("misalign",2'b01, 2'b11, 32'h0000_0102, 32'h0,        5'd4, 1, 32'h1111_2222, 1, 1, 1'b0, 2'b11, 32'h1111_2222, 2'b00);
`endif

        // Reset during the second WAIT cycle, then a stale ack
        MEM_M = 2'b01; WB_M = 2'b11; ALUOut_M = 32'h400; WriteReg_M = 5'd4;
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("rstwait_req_before", 32'(dmem_req), 32'd1);
        rst_n = 1'b0; MEM_M = '0; WB_M = '0; ALUOut_M = '0; WriteReg_M = '0;
        @(posedge clk); #1;
        check("rstwait_req",    32'(dmem_req),   32'd0);
        check("rstwait_stall",  32'(StallM),     32'd0);
        check("rstwait_WB_W",   32'(WB_W),       32'd0);
        check("rstwait_MemErr", 32'(MemErr_W),   32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        check("stale_ack_rdata", ReadData_W,     32'd0);
        check("stale_ack_WB_W",  32'(WB_W),      32'd0);
        check("stale_ack_req",   32'(dmem_req),  32'd0);
        check("stale_ack_stall", 32'(StallM),    32'd0);
        #1 dmem_ack = 1'b0;
        $display("txn reset_in_wait: stale ack applied");

        issue("alu3",    2'b00, 2'b01, 32'h0000_00AA, 32'h0,        5'd31, 0, 32'h0,        0, 0, 1'b0, 2'b01, 32'h0,         2'b00);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
